// File: rtl/spi_slave_dev.sv
// spi_slave_dev: oversampled SPI slave with RX FIFO and TX holding register.
// Define SPI_SLV_ECHO_EN to echo the last received byte when no TX byte is loaded.
module spi_slave_dev #(
  parameter int         RX_DEPTH = 4,
  parameter bit         CPOL     = 1'b0,
  parameter bit         CPHA     = 1'b0,
  parameter logic [7:0] TX_IDLE  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overflow,
  output logic       tx_underrun,
  output logic       frame_err,
  input  logic       clr_status
);
  localparam int AW = $clog2(RX_DEPTH);
`ifdef SPI_SLV_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state;
  logic [1:0] sck_s, ss_s, mosi_s;
  logic sck_q, lead, trail, smp, shf;
  logic [7:0] tx_reg, shift_tx, shift_rx, rx_byte, last_rx, nb, rx_next;
  logic tx_full, have_rx, fresh, pend, pend_src, byte_done;
  logic [2:0] bitcnt;
  logic [AW:0] wp, rp;
  logic [7:0] mem [RX_DEPTH];
  logic full, empty, pop, push;

  always_comb begin
    lead = (sck_q == CPOL) && (sck_s[1] != CPOL);
    trail = (sck_q != CPOL) && (sck_s[1] == CPOL);
    smp = CPHA ? trail : lead;
    shf = CPHA ? lead : trail;
    nb = tx_full ? tx_reg : (ECHO && have_rx) ? last_rx : TX_IDLE;
    rx_next = {shift_rx[6:0], mosi_s[1]};
  end

  // In mode CPHA=0 the next byte's MSB must be on miso before the byte starts, so
  // it is peeked early and only committed (consume/underrun) on its first sample.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sck_s <= {2{CPOL}};
      ss_s <= 2'b11;
      mosi_s <= '0;
      sck_q <= CPOL;
      miso <= 1'b1;
      tx_reg <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      rx_byte <= '0;
      last_rx <= '0;
      tx_full <= 1'b0;
      have_rx <= 1'b0;
      fresh <= 1'b0;
      pend <= 1'b0;
      pend_src <= 1'b0;
      byte_done <= 1'b0;
      bitcnt <= '0;
      tx_underrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], sck};
      ss_s <= {ss_s[0], ss_n};
      mosi_s <= {mosi_s[0], mosi};
      sck_q <= sck_s[1];
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b1;
          bitcnt <= '0;
          pend <= 1'b0;
          if (!ss_s[1]) state <= LOAD;
        end
        LOAD: begin
          state <= SHIFT;
          fresh <= 1'b1;
          shift_tx <= CPHA ? nb : {nb[6:0], 1'b0};
          if (!CPHA) miso <= nb[7];
          if (tx_full) tx_full <= 1'b0;
          else if (!ECHO) tx_underrun <= 1'b1;
        end
        SHIFT:
          if (ss_s[1]) begin
            state <= IDLE;
            miso <= 1'b1;
            bitcnt <= '0;
            pend <= 1'b0;
            if (bitcnt != '0) frame_err <= 1'b1;
          end else if (smp) begin
            shift_rx <= rx_next;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              byte_done <= 1'b1;
              rx_byte <= rx_next;
              last_rx <= rx_next;
              have_rx <= 1'b1;
            end
            if (pend) begin
              pend <= 1'b0;
              if (pend_src) tx_full <= 1'b0;
              else if (!ECHO) tx_underrun <= 1'b1;
            end
          end else if (shf) begin
            fresh <= 1'b0;
            if (bitcnt == '0 && !fresh) begin
              shift_tx <= {nb[6:0], 1'b0};
              miso <= nb[7];
              if (!CPHA) begin
                pend <= 1'b1;
                pend_src <= tx_full;
              end else if (tx_full) tx_full <= 1'b0;
              else if (!ECHO) tx_underrun <= 1'b1;
            end else begin
              miso <= shift_tx[7];
              shift_tx <= {shift_tx[6:0], 1'b0};
            end
          end
        default: state <= IDLE;
      endcase
      if (tx_valid && !tx_full) begin
        tx_reg <= tx_data;
        tx_full <= 1'b1;
      end
      if (clr_status) begin
        tx_underrun <= 1'b0;
        frame_err <= 1'b0;
      end
    end

  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    pop = !empty && rx_ready;
    push = byte_done && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      rx_overflow <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= rx_byte;
        wp <= wp + (AW+1)'(1);
      end
      if (pop) rp <= rp + (AW+1)'(1);
      if (byte_done && full && !pop) rx_overflow <= 1'b1;
      if (clr_status) rx_overflow <= 1'b0;
    end

  assign rx_valid = !empty;
  assign rx_data = mem[rp[AW-1:0]];
  assign tx_ready = !tx_full;
endmodule

// File: tb/tb_spi_slave_dev.sv
// tb_spi_slave_dev: drives a mode-0 and a mode-3 slave from a bench-side SPI master.
module tb_spi_slave_dev;
  localparam int HALF = 40;
`ifdef SPI_SLV_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck [2], ss_n [2], mosi [2], miso [2], rx_valid [2], rx_ready [2];
  logic tx_valid [2], tx_ready [2], rx_overflow [2], tx_underrun [2], frame_err [2], clr_status [2];
  logic [7:0] rx_data [2], tx_data [2];
  int errors = 0, checks = 0;
  logic [7:0] mlast = 8'h00;
  bit mhave = 1'b0;

  always #5 clk = ~clk;

  spi_slave_dev dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck[0]), .ss_n(ss_n[0]), .mosi(mosi[0]), .miso(miso[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_overflow(rx_overflow[0]),
    .tx_underrun(tx_underrun[0]), .frame_err(frame_err[0]), .clr_status(clr_status[0])
  );
  spi_slave_dev #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck[1]), .ss_n(ss_n[1]), .mosi(mosi[1]), .miso(miso[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_overflow(rx_overflow[1]),
    .tx_underrun(tx_underrun[1]), .frame_err(frame_err[1]), .clr_status(clr_status[1])
  );

  function automatic logic [3:0] flags(input int m);
    return {tx_ready[m], rx_overflow[m], tx_underrun[m], frame_err[m]};
  endfunction

  function automatic logic [13:0] outs(input int m);
    return {miso[m], rx_valid[m], rx_data[m], flags(m)};
  endfunction

  task automatic spi_bits(input int m, input logic [7:0] mo, input int n, input bit pop_last,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - n; i--) begin
      if (m == 1) sck[m] = 1'b0;
      mosi[m] = mo[i];
      #HALF;
      sck[m] = 1'b1;
      mi[i] = miso[m];
      if (pop_last && i == 0)
        fork
          begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            rx_ready[m] = 1'b1;
            @(negedge clk);
            rx_ready[m] = 1'b0;
          end
        join_none
      #HALF;
      if (m == 0) sck[m] = 1'b0;
    end
  endtask

  task automatic frame(input int m, input logic [39:0] mo, input int n, input bit pop_last,
                       output logic [39:0] mi);
    logic [7:0] b;
    mi = '0;
    @(negedge clk);
    ss_n[m] = 1'b0;
    #80;
    for (int k = 0; k < n; k++) begin
      spi_bits(m, mo[8*(n-1-k) +: 8], 8, pop_last && k == n - 1, b);
      mi = {mi[31:0], b};
    end
    #HALF;
    ss_n[m] = 1'b1;
    #200;
  endtask

  task automatic load_tx(input int m, input logic [7:0] d);
    @(negedge clk);
    tx_data[m] = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic clr(input int m);
    @(negedge clk);
    clr_status[m] = 1'b1;
    @(negedge clk);
    clr_status[m] = 1'b0;
  endtask

  task automatic drain(input int m, output logic [31:0] got, output int n);
    got = '0;
    n = 0;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      if (rx_valid[m] === 1'b1) begin
        got = {got[23:0], rx_data[m]};
        n++;
        rx_ready[m] = 1'b1;
        @(negedge clk);
        rx_ready[m] = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (outs(m) !== 14'b1_0_00000000_1000) begin
        errors++;
        $display("FAIL reset m%0d: got %b want %b", m, outs(m), 14'b1_0_00000000_1000);
      end
    end
  endtask

  task automatic test_basic;
    logic [39:0] mi;
    logic [31:0] got;
    int n;
    load_tx(0, 8'h3C);
    checks++;
    if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL basic_tx_ready: got %b want 0", tx_ready[0]); end
    frame(0, 40'hA5, 1, 1'b0, mi);
    checks++;
    if (mi[7:0] !== 8'h3C) begin errors++; $display("FAIL basic_miso: got %h want 3c", mi[7:0]); end
    checks++;
    if ({rx_valid[0], rx_data[0]} !== 9'h1A5) begin
      errors++; $display("FAIL basic_rx: got v=%b d=%h want v=1 d=a5", rx_valid[0], rx_data[0]);
    end
    checks++;
    if (flags(0) !== 4'b1000) begin errors++; $display("FAIL basic_flags: got %b want 1000", flags(0)); end
    drain(0, got, n);
    mlast = 8'hA5;
    mhave = 1'b1;
  endtask

  task automatic test_overflow;
    logic [39:0] mi;
    logic [31:0] got;
    int n;
    frame(0, 40'h0102030405, 5, 1'b0, mi);
    checks++;
    if (mi !== (ECHO ? 40'hA501020304 : 40'hFFFFFFFFFF)) begin
      errors++; $display("FAIL ovf_miso: got %h", mi);
    end
    checks++;
    if (flags(0) !== {1'b1, 1'b1, !ECHO, 1'b0}) begin
      errors++; $display("FAIL ovf_flags: got %b want %b", flags(0), {1'b1, 1'b1, !ECHO, 1'b0});
    end
    drain(0, got, n);
    checks++;
    if (n !== 4 || got !== 32'h01020304) begin errors++; $display("FAIL ovf_drain: got n=%0d %h want 4 01020304", n, got); end
    mlast = 8'h05;
    clr(0);
    checks++;
    if (flags(0) !== 4'b1000) begin errors++; $display("FAIL ovf_clr: got %b want 1000", flags(0)); end
  endtask

  task automatic test_frame_err;
    logic [7:0] b;
    logic [39:0] mi;
    logic [31:0] got;
    int n;
    @(negedge clk);
    ss_n[0] = 1'b0;
    #80;
    spi_bits(0, 8'hFF, 3, 1'b0, b);
    #HALF;
    ss_n[0] = 1'b1;
    #200;
    checks++;
    if ({rx_valid[0], frame_err[0]} !== 2'b01) begin
      errors++; $display("FAIL ferr: got v=%b fe=%b want v=0 fe=1", rx_valid[0], frame_err[0]);
    end
    clr(0);
    frame(0, 40'h5A, 1, 1'b0, mi);
    checks++;
    if (frame_err[0] !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b want 0", frame_err[0]); end
    drain(0, got, n);
    checks++;
    if (n !== 1 || got !== 32'h5A) begin errors++; $display("FAIL ferr_next_rx: got n=%0d %h want 1 5a", n, got); end
    mlast = 8'h5A;
    clr(0);
  endtask

  task automatic test_underrun;
    logic [39:0] mi;
    logic [31:0] got;
    int n;
    frame(0, 40'h1122, 2, 1'b0, mi);
    checks++;
    if (mi[15:0] !== (ECHO ? 16'h5A11 : 16'hFFFF)) begin errors++; $display("FAIL und_miso: got %h", mi[15:0]); end
    checks++;
    if (tx_underrun[0] !== !ECHO) begin errors++; $display("FAIL und_flag: got %b want %b", tx_underrun[0], !ECHO); end
    drain(0, got, n);
    checks++;
    if (n !== 2 || got !== 32'h1122) begin errors++; $display("FAIL und_rx: got n=%0d %h want 2 1122", n, got); end
    mlast = 8'h22;
    clr(0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    logic [39:0] mi;
    logic [31:0] got;
    int n;
    @(negedge clk);
    ss_n[0] = 1'b0;
    #80;
    spi_bits(0, 8'hC3, 4, 1'b0, b);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs(0) !== 14'b1_0_00000000_1000) begin errors++; $display("FAIL rstmid_in: got %b", outs(0)); end
    ss_n[0] = 1'b1;
    #50;
    @(negedge clk);
    rst_n = 1'b1;
    mhave = 1'b0;
    #100;
    checks++;
    if (outs(0) !== 14'b1_0_00000000_1000) begin errors++; $display("FAIL rstmid_after: got %b", outs(0)); end
    frame(0, 40'hC3, 1, 1'b0, mi);
    drain(0, got, n);
    checks++;
    if (n !== 1 || got !== 32'hC3) begin errors++; $display("FAIL rstmid_rx: got n=%0d %h want 1 c3", n, got); end
    mlast = 8'hC3;
    mhave = 1'b1;
    clr(0);
  endtask

  task automatic test_mode3;
    logic [39:0] mi;
    logic [31:0] got;
    int n;
    clr(1);
    load_tx(1, 8'h81);
    frame(1, 40'h7E, 1, 1'b0, mi);
    checks++;
    if (mi[7:0] !== 8'h81) begin errors++; $display("FAIL m3_miso: got %h want 81", mi[7:0]); end
    checks++;
    if (flags(1) !== 4'b1000) begin errors++; $display("FAIL m3_flags: got %b want 1000", flags(1)); end
    drain(1, got, n);
    checks++;
    if (n !== 1 || got !== 32'h7E) begin errors++; $display("FAIL m3_rx: got n=%0d %h want 1 7e", n, got); end
    frame(1, 40'h01020304, 4, 1'b0, mi);
    frame(1, 40'h05, 1, 1'b1, mi);
    checks++;
    if (rx_overflow[1] !== 1'b0) begin errors++; $display("FAIL m3_pushpop_ovf: got %b want 0", rx_overflow[1]); end
    drain(1, got, n);
    checks++;
    if (n !== 4 || got !== 32'h02030405) begin errors++; $display("FAIL m3_pushpop_rx: got n=%0d %h want 4 02030405", n, got); end
  endtask

  task automatic test_random;
    logic [39:0] mo, mi, exp_mi;
    logic [31:0] got, exp_rx;
    logic [7:0] t, b;
    int n, cnt;
    bit pre;
    clr(0);
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 4);
      pre = 1'($urandom_range(0, 1));
      t = 8'($urandom);
      mo = '0; exp_mi = '0; exp_rx = '0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        mo = {mo[31:0], b};
        exp_rx = {exp_rx[23:0], b};
        exp_mi = {exp_mi[31:0], (k == 0 && pre) ? t : (ECHO && mhave) ? mlast : 8'hFF};
        mlast = b;
        mhave = 1'b1;
      end
      if (pre) load_tx(0, t);
      frame(0, mo, n, 1'b0, mi);
      checks++;
      if (mi !== exp_mi) begin errors++; $display("FAIL rnd%0d_miso: got %h want %h", it, mi, exp_mi); end
      checks++;
      if (flags(0) !== {1'b1, 1'b0, !ECHO && (!pre || n > 1), 1'b0}) begin
        errors++; $display("FAIL rnd%0d_flags: got %b want %b", it, flags(0), {1'b1, 1'b0, !ECHO && (!pre || n > 1), 1'b0});
      end
      drain(0, got, cnt);
      checks++;
      if (cnt !== n || got !== exp_rx) begin errors++; $display("FAIL rnd%0d_rx: got n=%0d %h want %0d %h", it, cnt, got, n, exp_rx); end
      clr(0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      sck[m] = (m == 1);
      ss_n[m] = 1'b1;
      mosi[m] = 1'b0;
      rx_ready[m] = 1'b0;
      tx_valid[m] = 1'b0;
      tx_data[m] = '0;
      clr_status[m] = 1'b0;
    end
    #33;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset;
    test_basic;
    test_overflow;
    test_frame_err;
    test_underrun;
    test_reset_mid;
    test_mode3;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
